riscv_mem_arbiter: RTL and testbench

RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

---
 rtl/riscv_mem_arbiter_if.sv | 48 ++++
 rtl/riscv_mem_arbiter.sv | 112 +++++++++++
 tb/tb_riscv_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and one shared memory port.
// The master side drives the requests and the memory response; the slave
// side (the arbiter) drives read data, ready pulses and the memory request.
interface riscv_mem_arbiter_if;
  logic        m0_req_i;
  logic        m0_we_i;
  logic [3:0]  m0_be_i;
  logic [31:0] m0_addr_i;
  logic [31:0] m0_wd_i;
  logic [31:0] m0_rd_o;
  logic        m0_ready_o;

  logic        m1_req_i;
  logic        m1_we_i;
  logic [3:0]  m1_be_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_wd_i;
  logic [31:0] m1_rd_o;
  logic        m1_ready_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  logic [1:0]  grant_o;

  modport master (
    output m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wd_i,
    output m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wd_i,
    output mem_rd_i, mem_ready_i,
    input  m0_rd_o, m0_ready_o, m1_rd_o, m1_ready_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    input  grant_o
  );

  modport slave (
    input  m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wd_i,
    input  m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wd_i,
    input  mem_rd_i, mem_ready_i,
    output m0_rd_o, m0_ready_o, m1_rd_o, m1_ready_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    output grant_o
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Two-requester arbiter in front of a single memory port. One transaction is
// in flight at a time; the winner's command is captured on grant and held on
// the memory port until the memory signals completion. Ties go round-robin
// (FIXED_PRIO=0) or always to m1 (FIXED_PRIO=1).
module riscv_mem_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  riscv_mem_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q;
  logic        last_m1_q;   // 1 when m1 was served last; reset value makes m0 win the first tie
  logic        pick_m1;
  logic        load;
  logic        done;

  logic        req_we_q;
  logic [3:0]  req_be_q;
  logic [31:0] req_addr_q;
  logic [31:0] req_wd_q;

  // Next-state, winner selection and completion detect
  always_comb begin
    state_d = state_q;
    pick_m1 = 1'b0;
    load    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.m0_req_i && bus.m1_req_i) begin
          pick_m1 = (FIXED_PRIO != 0) ? 1'b1 : !last_m1_q;
        end else begin
          pick_m1 = bus.m1_req_i;
        end
        if (bus.m0_req_i || bus.m1_req_i) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_ready_i) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Owner and round-robin pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_q   <= 2'b00;
      last_m1_q <= 1'b1;
    end else if (load) begin
      grant_q   <= pick_m1 ? 2'b10 : 2'b01;
    end else if (done) begin
      grant_q   <= 2'b00;
      last_m1_q <= grant_q[1];
    end
  end

  // Request register: the winner's command, frozen for the whole transaction
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_we_q   <= 1'b0;
      req_be_q   <= 4'b0000;
      req_addr_q <= 32'h0;
      req_wd_q   <= 32'h0;
    end else if (load) begin
      if (pick_m1) begin
        req_we_q   <= bus.m1_we_i;
        req_be_q   <= bus.m1_be_i;
        req_addr_q <= bus.m1_addr_i;
        req_wd_q   <= bus.m1_wd_i;
      end else begin
        req_we_q   <= bus.m0_we_i;
        req_be_q   <= bus.m0_be_i;
        req_addr_q <= bus.m0_addr_i;
        req_wd_q   <= bus.m0_wd_i;
      end
    end
  end

  assign bus.mem_req_o  = (state_q == BUSY);
  assign bus.mem_we_o   = req_we_q;
  assign bus.mem_be_o   = req_be_q;
  assign bus.mem_addr_o = req_addr_q;
  assign bus.mem_wd_o   = req_wd_q;
  assign bus.grant_o    = grant_q;

  // Completion is routed only to the owner; the other side sees zeros
  assign bus.m0_ready_o = done && grant_q[0];
  assign bus.m1_ready_o = done && grant_q[1];
  assign bus.m0_rd_o    = bus.m0_ready_o ? bus.mem_rd_i : 32'h0;
  assign bus.m1_rd_o    = bus.m1_ready_o ? bus.mem_rd_i : 32'h0;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: a round-robin instance under scoreboard
// checking, plus a fixed-priority instance fed the same inputs.
module tb_riscv_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_mem_arbiter_if bus();
  riscv_mem_arbiter_if bus_fp();

  riscv_mem_arbiter #(.FIXED_PRIO(0)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  riscv_mem_arbiter #(.FIXED_PRIO(1)) dut_fp (.clk_i(clk), .rst_i(rst), .bus(bus_fp));

  assign bus_fp.m0_req_i    = bus.m0_req_i;
  assign bus_fp.m0_we_i     = bus.m0_we_i;
  assign bus_fp.m0_be_i     = bus.m0_be_i;
  assign bus_fp.m0_addr_i   = bus.m0_addr_i;
  assign bus_fp.m0_wd_i     = bus.m0_wd_i;
  assign bus_fp.m1_req_i    = bus.m1_req_i;
  assign bus_fp.m1_we_i     = bus.m1_we_i;
  assign bus_fp.m1_be_i     = bus.m1_be_i;
  assign bus_fp.m1_addr_i   = bus.m1_addr_i;
  assign bus_fp.m1_wd_i     = bus.m1_wd_i;
  assign bus_fp.mem_rd_i    = bus.mem_rd_i;
  assign bus_fp.mem_ready_i = bus.mem_ready_i;

  typedef struct {
    logic [1:0]  own;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] ghist[$];
  logic [1:0] grant_prev = 2'b00;

  int n_chk = 0;
  int n_bad = 0;
  int p0 = 0, p1 = 0, fp1 = 0;
  int req_cycles = 0;
  int busy_cnt = 0;
  int lat = 0;
  bit force_ready = 1'b0;
  bit hold = 1'b0;
  bit fp_chk = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'h5A5A_C3C3);
  endfunction

  // Memory stub drives at negedge; monitor/scoreboard samples 1 later
  always @(negedge clk) begin
    if (force_ready) begin
      bus.mem_ready_i = 1'b1;
      bus.mem_rd_i    = rd_of(bus.mem_addr_o);
    end else if (bus.mem_req_o) begin
      bus.mem_ready_i = (busy_cnt >= lat);
      bus.mem_rd_i    = bus.mem_ready_i ? rd_of(bus.mem_addr_o) : 32'h1234_5678;
      busy_cnt++;
    end else begin
      bus.mem_ready_i = 1'b0;
      bus.mem_rd_i    = 32'h1234_5678;
      busy_cnt = 0;
    end
    #1;
    if (!rst) begin
      if (bus.mem_req_o) req_cycles++;
      if (bus.grant_o != grant_prev) begin
        ghist.push_back(bus.grant_o);
        grant_prev = bus.grant_o;
      end
      if (bus.m0_ready_o || bus.m1_ready_o) begin
        if (bus.m0_ready_o) begin
          p0++;
          if (!hold) bus.m0_req_i = 1'b0;
        end
        if (bus.m1_ready_o) begin
          p1++;
          if (!hold) bus.m1_req_i = 1'b0;
        end
        if (sb.size() == 0) begin
          chk("sb_underflow", {bus.m1_ready_o, bus.m0_ready_o}, 2'b00);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rdy_who", {bus.m1_ready_o, bus.m0_ready_o}, e.own);
          chk("grant", bus.grant_o, e.own);
          chk("mem_addr", bus.mem_addr_o, e.addr);
          chk("mem_ctl", {bus.mem_we_o, bus.mem_be_o}, {e.we, e.be});
          chk("mem_wd", bus.mem_wd_o, e.wd);
          chk("rd_owner", e.own[1] ? bus.m1_rd_o : bus.m0_rd_o, e.rd);
          chk("rd_other", e.own[1] ? bus.m0_rd_o : bus.m1_rd_o, 32'h0);
        end
      end
      if (fp_chk) begin
        if (bus_fp.mem_req_o) chk("fp_grant", bus_fp.grant_o, 2'b10);
        chk("fp_m0_ready", bus_fp.m0_ready_o, 1'b0);
        if (bus_fp.m1_ready_o) fp1++;
      end
    end
  end

  task automatic issue(input int m, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd, input bit push);
    exp_t e;
    if (m == 0) begin
      bus.m0_we_i = we; bus.m0_be_i = be; bus.m0_addr_i = addr; bus.m0_wd_i = wd;
      bus.m0_req_i = 1'b1;
    end else begin
      bus.m1_we_i = we; bus.m1_be_i = be; bus.m1_addr_i = addr; bus.m1_wd_i = wd;
      bus.m1_req_i = 1'b1;
    end
    if (push) begin
      e.own = (m == 0) ? 2'b01 : 2'b10;
      e.we = we; e.be = be; e.addr = addr; e.wd = wd; e.rd = rd_of(addr);
      sb.push_back(e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pulses(input string tag, input int target, input int budget);
    int k = 0;
    while ((p0 + p1) < target && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    if ((p0 + p1) < target) chk({tag, "_timeout"}, p0 + p1, target);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_mem"}, {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wd_o}, 70'h0);
    chk({tag, "_grant"}, bus.grant_o, 2'b00);
    chk({tag, "_ready"}, {bus.m1_ready_o, bus.m0_ready_o}, 2'b00);
    chk({tag, "_rd"}, {bus.m1_rd_o, bus.m0_rd_o}, 64'h0);
  endtask

  task automatic do_reset();
    bus.m0_req_i = 1'b0;
    bus.m1_req_i = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int base;
    logic [7:0] gseq;
    bus.m0_req_i = 1'b0; bus.m0_we_i = 1'b0; bus.m0_be_i = 4'h0; bus.m0_addr_i = 32'h0; bus.m0_wd_i = 32'h0;
    bus.m1_req_i = 1'b0; bus.m1_we_i = 1'b0; bus.m1_be_i = 4'h0; bus.m1_addr_i = 32'h0; bus.m1_wd_i = 32'h0;
    bus.mem_rd_i = 32'h0; bus.mem_ready_i = 1'b0;

    rst = 1'b1;
    step(3);
    check_reset_outs("rst0");
    rst = 1'b0;
    step(1);

    // Single read with 2-cycle memory latency
    lat = 2;
    req_cycles = 0;
    issue(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1);
    wait_pulses("rd1", 1, 30);
    step(2);
    chk("rd1_req_cycles", req_cycles, 3);
    chk("rd1_p0", p0, 1);
    chk("rd1_p1", p1, 0);

    // Simultaneous requests after reset, zero latency
    do_reset();
    lat = 0;
    ghist.delete();
    grant_prev = 2'b00;
    base = p0 + p1;
    issue(0, 1'b1, 4'b0001, 32'h4, 32'hAA, 1'b1);
    issue(1, 1'b0, 4'hF, 32'h8, 32'h0, 1'b1);
    wait_pulses("sim", base + 2, 30);
    step(2);
    chk("sim_ghist_n", ghist.size(), 4);
    gseq = 8'hFF;
    if (ghist.size() == 4) gseq = {ghist[0], ghist[1], ghist[2], ghist[3]};
    chk("sim_gseq", gseq, 8'b01_00_10_00);

    // Continuous dual requests: alternation (rr) and m1-only (fixed)
    do_reset();
    hold = 1'b1;
    fp_chk = 1'b1;
    fp1 = 0;
    base = p0 + p1;
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.own  = (i % 2 == 0) ? 2'b01 : 2'b10;
      e.we   = (i % 2 == 1);
      e.be   = (i % 2 == 0) ? 4'hF : 4'b1100;
      e.addr = (i % 2 == 0) ? 32'h100 : 32'h200;
      e.wd   = (i % 2 == 0) ? 32'h0 : 32'h0C0F_FEE0;
      e.rd   = rd_of(e.addr);
      sb.push_back(e);
    end
    issue(0, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0);
    issue(1, 1'b1, 4'b1100, 32'h200, 32'h0C0F_FEE0, 1'b0);
    force_ready = 1'b1;
    wait_pulses("cont", base + 8, 60);
    bus.m0_req_i = 1'b0;
    bus.m1_req_i = 1'b0;
    hold = 1'b0;
    force_ready = 1'b0;
    step(2);
    fp_chk = 1'b0;
    chk("cont_fp_m1", fp1, 8);
    chk("cont_total", p0 + p1 - base, 8);

    // Owner drops req and changes addr while BUSY
    lat = 3;
    base = p0 + p1;
    issue(0, 1'b0, 4'hF, 32'h40, 32'h0, 1'b1);
    step(1);
    bus.m0_req_i = 1'b0;
    bus.m0_addr_i = 32'hFFFF_0000;
    bus.m0_we_i = 1'b1;
    bus.m0_wd_i = 32'h5555_AAAA;
    chk("drop_addr0", bus.mem_addr_o, 32'h40);
    step(1);
    chk("drop_addr1", {bus.mem_we_o, bus.mem_addr_o}, {1'b0, 32'h40});
    wait_pulses("drop", base + 1, 30);
    step(2);
    chk("drop_p0", p0 + p1 - base, 1);

    // Reset while BUSY abandons the transaction; next tie goes to m0
    lat = 10;
    issue(1, 1'b0, 4'hF, 32'h80, 32'h0, 1'b0);
    step(1);
    chk("abort_busy_grant", bus.grant_o, 2'b10);
    rst = 1'b1;
    force_ready = 1'b1;
    bus.m1_req_i = 1'b0;
    step(1);
    check_reset_outs("rst_busy");
    rst = 1'b0;
    base = p0 + p1;
    step(3);
    chk("abort_no_pulse", p0 + p1, base);
    force_ready = 1'b0;
    lat = 1;
    step(1);
    issue(0, 1'b1, 4'b0011, 32'h300, 32'h1357_9BDF, 1'b1);
    issue(1, 1'b0, 4'hF, 32'h304, 32'h0, 1'b1);
    wait_pulses("tie", base + 2, 30);
    step(2);
    chk("sb_left", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
